// File: rtl/reward_effect_timer.sv
// Converts one-cycle reward pickups into four independent 4 Hz countdown effects plus an addtime pulse.
// Define REWARD_STACK_EN to make re-pickups add DURATION (saturating) instead of refreshing.
`timescale 1ns/1ps
module reward_effect_timer #(
  parameter int DURATION = 20,
  parameter int CW       = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_4Hz,
  input  logic            enable_game_classic,
  input  logic            enable_game_infinity,
  input  logic            pause,
  input  logic            pick_valid,
  input  logic [2:0]      pick_type,
  output logic            pick_ack,
  output logic            addtime_pulse,
  output logic            effect_invincible,
  output logic            effect_faster,
  output logic            effect_frozen,
  output logic            effect_laser,
  output logic [4*CW-1:0] effect_remain
);

  localparam logic [CW-1:0] DUR = CW'(DURATION);

  logic       clk4_q;
  logic       tick;
  logic       mode_on;
  logic [3:0] load;
  logic [3:0] active;
  logic       addtime_d;
  logic       pick_ack_d;
  logic       pick_ack_q;
  logic       addtime_q;

  assign tick    = clk_4Hz & ~clk4_q;
  assign mode_on = enable_game_classic | enable_game_infinity;

  // Time-bonus pickup only gives addtime when classic mode is not claiming it as invincibility.
  always_comb begin
    load[0]    = pick_valid & enable_game_classic & (pick_type == 3'd1);
    load[1]    = pick_valid & mode_on & (pick_type == 3'd2);
    load[2]    = pick_valid & mode_on & (pick_type == 3'd3);
    load[3]    = pick_valid & mode_on & (pick_type == 3'd4);
    addtime_d  = pick_valid & ~enable_game_classic & enable_game_infinity & (pick_type == 3'd1);
    pick_ack_d = (|load) | addtime_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_effect
      logic [CW-1:0] rem_q;
      logic [CW-1:0] rem_d;
      logic [CW-1:0] dec;
`ifdef REWARD_STACK_EN
      logic [CW:0]   sum;
`endif

      always_comb begin
        dec = rem_q;
        if (tick && !pause && (rem_q != '0)) begin
          dec = rem_q - 1'b1;
        end
`ifdef REWARD_STACK_EN
        sum = {1'b0, dec} + {1'b0, DUR};
`endif
        rem_d = dec;
        if (!mode_on) begin
          rem_d = '0;
        end else if (load[gi]) begin
`ifdef REWARD_STACK_EN
          // Stack on top of the post-tick count; saturate rather than wrap.
          if (rem_q != '0) begin
            rem_d = sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
          end else begin
            rem_d = DUR;
          end
`else
          rem_d = DUR;
`endif
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_q <= '0;
        end else begin
          rem_q <= rem_d;
        end
      end

      assign active[gi]                 = (rem_q != '0);
      assign effect_remain[gi*CW +: CW] = rem_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk4_q     <= 1'b0;
      pick_ack_q <= 1'b0;
      addtime_q  <= 1'b0;
    end else begin
      clk4_q     <= clk_4Hz;
      pick_ack_q <= pick_ack_d;
      addtime_q  <= addtime_d;
    end
  end

  assign pick_ack          = pick_ack_q;
  assign addtime_pulse     = addtime_q;
  assign effect_invincible = active[0];
  assign effect_faster     = active[1];
  assign effect_frozen     = active[2];
  assign effect_laser      = active[3];

endmodule

// File: tb/tb_reward_effect_timer.sv
// Scoreboard bench for reward_effect_timer: a reference model pushes per-cycle expectations, compared after each edge.
`timescale 1ns/1ps
module tb_reward_effect_timer;
  localparam int CW       = 5;
  localparam int DURATION = 20;
  localparam int SAT      = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clk_4Hz = 1'b0;
  logic            classic = 1'b0;
  logic            infinity = 1'b0;
  logic            pause = 1'b0;
  logic            pick_valid = 1'b0;
  logic [2:0]      pick_type = 3'd0;
  logic            pick_ack;
  logic            addtime_pulse;
  logic            effect_invincible;
  logic            effect_faster;
  logic            effect_frozen;
  logic            effect_laser;
  logic [4*CW-1:0] effect_remain;

  reward_effect_timer #(.DURATION(DURATION), .CW(CW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .clk_4Hz             (clk_4Hz),
    .enable_game_classic (classic),
    .enable_game_infinity(infinity),
    .pause               (pause),
    .pick_valid          (pick_valid),
    .pick_type           (pick_type),
    .pick_ack            (pick_ack),
    .addtime_pulse       (addtime_pulse),
    .effect_invincible   (effect_invincible),
    .effect_faster       (effect_faster),
    .effect_frozen       (effect_frozen),
    .effect_laser        (effect_laser),
    .effect_remain       (effect_remain)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            ack;
    logic            add;
    logic [3:0]      eff;
    logic [4*CW-1:0] rem;
  } exp_t;

  exp_t exp_q[$];
  int   m_rem[4];
  bit   m_clk4;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.ack = pick_ack;
    o.add = addtime_pulse;
    o.eff = {effect_laser, effect_frozen, effect_faster, effect_invincible};
    o.rem = effect_remain;
    return o;
  endfunction

  function automatic logic [31:0] rem(input int i);
    return 32'(effect_remain[i*CW +: CW]);
  endfunction

  // One clock: model the expected post-edge outputs, push, clock, pop and compare.
  task automatic cycle();
    exp_t e;
    exp_t got;
    exp_t want;
    int   nrem[4];
    bit   tk;
    bit   mode;
    bit   hit;
    e = '0;
    if (rst_n) begin
      tk   = clk_4Hz && !m_clk4;
      mode = classic || infinity;
      for (int i = 0; i < 4; i++) begin
        hit = pick_valid && mode &&
              ((i == 0) ? (pick_type == 3'd1 && classic) : (int'(pick_type) == i + 1));
        nrem[i] = m_rem[i];
        if (tk && !pause && nrem[i] > 0) nrem[i]--;
        if (!mode) begin
          nrem[i] = 0;
        end else if (hit) begin
`ifdef REWARD_STACK_EN
          if (m_rem[i] > 0) nrem[i] = (nrem[i] + DURATION > SAT) ? SAT : nrem[i] + DURATION;
          else              nrem[i] = DURATION;
`else
          nrem[i] = DURATION;
`endif
          e.ack = 1'b1;
        end
      end
      if (pick_valid && pick_type == 3'd1 && !classic && infinity) begin
        e.ack = 1'b1;
        e.add = 1'b1;
      end
    end else begin
      for (int i = 0; i < 4; i++) nrem[i] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      e.eff[i]           = (nrem[i] != 0);
      e.rem[i*CW +: CW]  = CW'(nrem[i]);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    m_clk4 = rst_n ? clk_4Hz : 1'b0;
    for (int i = 0; i < 4; i++) m_rem[i] = nrem[i];
    want = exp_q.pop_front();
    got  = observe();
    check("sb_cycle", 32'(got), 32'(want));
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      clk_4Hz = 1'b1;
      cycle();
      clk_4Hz = 1'b0;
      cycle();
    end
  endtask

  task automatic pick(input logic [2:0] t);
    pick_valid = 1'b1;
    pick_type  = t;
    cycle();
    pick_valid = 1'b0;
    pick_type  = 3'd0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_rem[i] = 0;
    m_clk4 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(observe()), 32'd0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Faster pickup in classic mode, then full countdown.
    classic = 1'b1;
    pick(3'd2);
    check("faster_ack", 32'(pick_ack), 32'd1);
    check("faster_load", rem(1), 32'(DURATION));
    check("faster_flag", 32'(effect_faster), 32'd1);
    cycle();
    check("faster_ack_one_cycle", 32'(pick_ack), 32'd0);
    tick(19);
    check("faster_at_19", rem(1), 32'd1);
    tick(1);
    check("faster_expired_flag", 32'(effect_faster), 32'd0);
    check("faster_expired_rem", rem(1), 32'd0);

    // Infinity-mode time bonus.
    classic  = 1'b0;
    infinity = 1'b1;
    pick(3'd1);
    check("addtime_pulse", 32'(addtime_pulse), 32'd1);
    check("addtime_ack", 32'(pick_ack), 32'd1);
    check("addtime_no_inv", 32'(effect_remain), 32'd0);
    cycle();
    check("addtime_one_cycle", 32'(addtime_pulse), 32'd0);

    // Pickup coinciding with a tick: load wins, others still decrement.
    classic  = 1'b1;
    infinity = 1'b0;
    pick(3'd1);
    pick(3'd3);
    tick(13);
    check("frozen_at_7", rem(2), 32'd7);
    pick_valid = 1'b1;
    pick_type  = 3'd3;
    clk_4Hz    = 1'b1;
    cycle();
    pick_valid = 1'b0;
    clk_4Hz    = 1'b0;
`ifdef REWARD_STACK_EN
    check("frozen_stack", rem(2), 32'd26);
`else
    check("frozen_reload", rem(2), 32'(DURATION));
`endif
    check("inv_decrements_same_tick", rem(0), 32'd6);
`ifdef REWARD_STACK_EN
    pick(3'd3);
    check("frozen_saturate", rem(2), 32'(SAT));
`endif
    cycle();

    // Pause holds the laser counter.
    pick(3'd4);
    tick(10);
    check("laser_at_10", rem(3), 32'd10);
    pause = 1'b1;
    tick(8);
    check("laser_paused", rem(3), 32'd10);
    pause = 1'b0;
    tick(9);
    check("laser_before_last", 32'(effect_laser), 32'd1);
    tick(1);
    check("laser_last_tick", 32'(effect_laser), 32'd0);

    // Both modes: classic wins for type 1.
    infinity = 1'b1;
    pick(3'd1);
    check("both_modes_inv", rem(0), 32'(DURATION));
    check("both_modes_no_add", 32'(addtime_pulse), 32'd0);
    infinity = 1'b0;

    // Invalid types are ignored.
    pick(3'd0);
    check("type0_no_ack", 32'(pick_ack), 32'd0);
    pick(3'd5);
    check("type5_no_ack", 32'(pick_ack), 32'd0);
    pick(3'd7);
    check("type7_no_ack", 32'(pick_ack), 32'd0);

    // Mode exit clears everything; pickups then ignored.
    classic = 1'b0;
    cycle();
    check("mode_exit_clear", 32'(effect_remain), 32'd0);
    pick(3'd4);
    check("no_mode_no_ack", 32'(pick_ack), 32'd0);
    check("no_mode_no_laser", 32'(effect_laser), 32'd0);

    // Asynchronous reset mid-count.
    classic = 1'b1;
    pick(3'd1);
    pick(3'd2);
    tick(3);
    check("inv_before_reset", rem(0), 32'd17);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(observe()), 32'd0);
    for (int i = 0; i < 4; i++) m_rem[i] = 0;
    m_clk4 = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    tick(3);
    check("no_reactivate", 32'(effect_remain), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reward_effect_timer.md
Name: reward_effect_timer

Overview:
- Downstream consumer of reward pickup events produced by the reward pickup logic.
- Turns each one-cycle pickup event into a timed power-up effect: invincible, faster, frozen or laser.
- Each effect has its own down-counter that decrements on a 4 Hz game tick. A time-bonus pickup produces a one-cycle addtime pulse for the game timer.
- Outputs drive tank movement, enemy AI freeze, bullet logic and the HUD remaining-time bars.

Parameters:
DURATION, 20, effect length in 4 Hz ticks (20 = 5 s); must be 1..2^CW-1
CW, 5, width of each per-effect remaining-tick counter

Ports:
clk  input  1  system clock (all logic on rising edge)
rst_n  input  1  asynchronous active-low reset
clk_4Hz  input  1  4 Hz square wave, synchronous to clk; rising edge is the game tick
enable_game_classic  input  1  classic mode active
enable_game_infinity  input  1  infinity mode active
pause  input  1  while 1, no countdown occurs
pick_valid  input  1  one-cycle pulse: reward collected
pick_type  input  3  1=invincible/addtime, 2=faster, 3=frozen, 4=laser
pick_ack  output  1  one-cycle pulse: pickup accepted
addtime_pulse  output  1  one-cycle pulse: add bonus time (infinity mode)
effect_invincible  output  1  invincibility active
effect_faster  output  1  speed-up active
effect_frozen  output  1  enemies frozen
effect_laser  output  1  laser active
effect_remain  output  4*CW  remaining ticks; [CW-1:0]=invincible, then faster, frozen, laser

Behaviour:
- Reset (async, rst_n=0): all four counters = 0, all effect_* = 0, pick_ack = 0, addtime_pulse = 0, tick edge-detect register = 0.
- Tick detect:
  - clk_4Hz is registered once.
  - tick = clk_4Hz & ~clk_4Hz_d, a one-clk pulse.
  - The first rising edge after reset is a valid tick.
- Per-effect counter:
  - effect_X = (remain_X != 0), combinational from the counter.
  - On tick with pause=0 and remain_X>0: remain_X decrements by 1.
  - On tick with pause=1: counter holds.
  - A counter never wraps below 0.
- Pickup decode on the clk cycle where pick_valid=1 (results registered; visible the next cycle):
  - type 1 and classic=1 → remain_invincible loads DURATION.
  - type 1 and infinity=1 (classic=0) → addtime_pulse=1 for one cycle; no counter change.
  - type 1 with both modes 1 → classic has priority (invincible).
  - type 2/3/4 → faster/frozen/laser counter loads DURATION.
  - Accepted pickup → pick_ack=1 for exactly one cycle, one cycle after pick_valid.
  - type 0, 5, 6, 7, or both modes 0 → ignored: no ack, no state change.
- Re-pickup of an already active effect: counter reloads DURATION (refresh, no stacking).
- Other effects are unaffected by a pickup of a different type; effects run independently and concurrently.
- Simultaneous pick_valid and tick on the same effect: the load wins; the counter equals DURATION the next cycle. Other counters still decrement on that tick.
- Mode exit: when enable_game_classic=0 and enable_game_infinity=0:
  - all counters clear to 0 on the next clk;
  - pending pulses are not generated.
- pick_valid held high for N cycles is treated as N pickups. Each one reloads the counter and acks; this is legal but not expected from upstream.
- Latency:
  - pickup → effect flag: 1 clk;
  - tick edge → counter update: 1 clk after the registered rising edge;
  - DURATION=20 gives the effect high for exactly 20 ticks when pause=0.

Optional Feature:
- Macro: REWARD_STACK_EN.
- Defined: re-pickup of an active effect adds DURATION to the current remaining count, saturating at 2^CW-1 (31 for CW=5). A pickup on an inactive effect loads DURATION as normal. Addtime behaviour is unchanged.
- Undefined: refresh behaviour as in Behaviour (reload to DURATION).

Test Plan:
1. Reset → all outputs 0. Classic=1, pick_type=2 pulse → next clk: effect_faster=1, remain_faster=20, pick_ack=1 for 1 clk. After 20 ticks → effect_faster=0, remain_faster=0.
2. Infinity=1, classic=0, pick_type=1 → addtime_pulse=1 for exactly 1 clk, pick_ack=1, effect_invincible stays 0, all counters 0.
3. Frozen active at remain=7, pick_type=3 on the same clk as a tick → remain_frozen=20 next clk. With REWARD_STACK_EN, the same stimulus gives 26; a third pickup at 26 saturates to 31.
4. Laser at remain=10, pause=1 for 8 ticks → remain stays 10. pause=0, 10 ticks → effect_laser=0 exactly at the 10th tick.
5. pick_type=0, 5 and 7 pulses; then pick_type=4 with both modes 0 → no ack, no state change.
6. Invincible and faster both active, rst_n asserted mid-count → all outputs 0 immediately (asynchronous); after release, no effect reactivates without a new pickup.
